// File: rtl/multi_channel_fir_filter_pkg.sv
// fir_pkg: FSM state type and counter-width helper shared by the FIR frame collector and serializer
package fir_pkg;
  typedef enum logic [1:0] {COLLECT, PROCESS, EMIT} state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_channel_fir_filter_if.sv
// multi_channel_fir_filter_if: AXI-stream bundle (data/valid/last from master, ready from slave)
interface multi_channel_fir_filter_if #(parameter int DATA_WIDTH = 24) ();
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic ready;
  logic last;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/multi_channel_fir_filter_serializer.sv
// fir_frame_serializer: buffers one engine result frame on load and streams it word by word on m_axis (valid/last/data), done on the last handshake
module fir_frame_serializer import fir_pkg::*; #(
  parameter int DATA_WIDTH = 24,
  parameter int N_CHANNELS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] load_data,
  multi_channel_fir_filter_if.master       m_axis,
  output logic                             done
);
  localparam int CW = clog2_min1(N_CHANNELS);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CHANNELS - 1);
  logic [N_CHANNELS*DATA_WIDTH-1:0] obuf_q, obuf_d;
  logic [CW-1:0] m_cnt_q, m_cnt_d;
  logic valid_q, valid_d, hs, at_last;
  assign hs = valid_q && m_axis.ready;
  assign at_last = m_cnt_q == LAST_CH;
  assign done = hs && at_last;
  assign m_axis.valid = valid_q;
  assign m_axis.last = valid_q && at_last;
  assign m_axis.data = valid_q ? obuf_q[m_cnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    obuf_d = load ? load_data : obuf_q;
    m_cnt_d = !hs ? m_cnt_q : at_last ? '0 : m_cnt_q + 1'b1;
    valid_d = load ? 1'b1 : done ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_q <= '0;
      m_cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      obuf_q <= obuf_d;
      m_cnt_q <= m_cnt_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/multi_channel_fir_filter.sv
// multi_channel_fir_filter: collects N_CHANNELS-word frames from s_axis, starts the external engine (eng_start/eng_sw/eng_in_data), streams eng_out_data on m_axis after eng_done; FIR_FRAME_CHECK_EN enables s_axis_last checking with frame_err pulses
module multi_channel_fir_filter import fir_pkg::*; #(
  parameter int DATA_WIDTH = 24,
  parameter int N_CHANNELS = 2,
  parameter int N_FILTERS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_FILTERS-1:0]             sw,
  multi_channel_fir_filter_if.slave        s_axis,
  multi_channel_fir_filter_if.master       m_axis,
  output logic                             eng_start,
  output logic [N_FILTERS-1:0]             eng_sw,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] eng_in_data,
  input  logic                             eng_done,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] eng_out_data,
  output logic                             frame_err
);
  localparam int CW = clog2_min1(N_CHANNELS);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CHANNELS - 1);
  state_t state_q, state_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [N_CHANNELS*DATA_WIDTH-1:0] eng_in_q, eng_in_d;
  logic [N_FILTERS-1:0] eng_sw_q, eng_sw_d;
  logic eng_start_q, eng_start_d, frame_err_q, frame_err_d;
  logic accept, slot_last, short_frame, load, emit_done;
  assign s_axis.ready = state_q == COLLECT;
  assign accept = s_axis.valid && s_axis.ready;
  assign slot_last = ch_cnt_q == LAST_CH;
  assign load = (state_q == PROCESS) && eng_done;
`ifdef FIR_FRAME_CHECK_EN
  assign short_frame = accept && s_axis.last && !slot_last;
  assign frame_err_d = short_frame || (accept && slot_last && !s_axis.last);
`else
  logic unused_last;
  assign unused_last = s_axis.last;
  assign short_frame = 1'b0;
  assign frame_err_d = 1'b0;
`endif
  always_comb begin
    eng_in_d = eng_in_q;
    if (accept) eng_in_d[ch_cnt_q*DATA_WIDTH +: DATA_WIDTH] = s_axis.data;
    ch_cnt_d = !accept ? ch_cnt_q : (slot_last || short_frame) ? '0 : ch_cnt_q + 1'b1;
    eng_start_d = accept && slot_last;
    eng_sw_d = eng_start_d ? sw : eng_sw_q;
    state_d = eng_start_d ? PROCESS : load ? EMIT : emit_done ? COLLECT : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      ch_cnt_q <= '0;
      eng_in_q <= '0;
      eng_sw_q <= '0;
      eng_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_cnt_q <= ch_cnt_d;
      eng_in_q <= eng_in_d;
      eng_sw_q <= eng_sw_d;
      eng_start_q <= eng_start_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign eng_start = eng_start_q;
  assign eng_sw = eng_sw_q;
  assign eng_in_data = eng_in_q;
  assign frame_err = frame_err_q;
  fir_frame_serializer #(.DATA_WIDTH(DATA_WIDTH), .N_CHANNELS(N_CHANNELS)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_data(eng_out_data),
    .m_axis(m_axis),
    .done(emit_done)
  );
endmodule

// File: tb/tb_multi_channel_fir_filter.sv
// tb_multi_channel_fir_filter: directed table-driven bench for the 4-channel filter wrapper plus a 1-channel instance, with a +1 engine model of latency 3
module tb_multi_channel_fir_filter;
  localparam int DW = 24;
  localparam int NC = 4;
  localparam int NF = 4;
  typedef struct {
    logic [DW-1:0] din;
    logic          lst;
    logic [DW-1:0] dout;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [NF-1:0] sw = '0;
  logic eng_start, eng_done, frame_err;
  logic [NF-1:0] eng_sw;
  logic [NC*DW-1:0] eng_in, eng_out;
  logic eng1_start, eng1_done, frame1_err;
  logic [NF-1:0] eng1_sw;
  logic [DW-1:0] eng1_in, eng1_out;
  multi_channel_fir_filter_if #(.DATA_WIDTH(DW)) s_if();
  multi_channel_fir_filter_if #(.DATA_WIDTH(DW)) m_if();
  multi_channel_fir_filter_if #(.DATA_WIDTH(DW)) s1_if();
  multi_channel_fir_filter_if #(.DATA_WIDTH(DW)) m1_if();
  multi_channel_fir_filter #(.DATA_WIDTH(DW), .N_CHANNELS(NC), .N_FILTERS(NF)) dut (
    .clk(clk), .rst(rst), .sw(sw), .s_axis(s_if), .m_axis(m_if),
    .eng_start(eng_start), .eng_sw(eng_sw), .eng_in_data(eng_in),
    .eng_done(eng_done), .eng_out_data(eng_out), .frame_err(frame_err)
  );
  multi_channel_fir_filter #(.DATA_WIDTH(DW), .N_CHANNELS(1), .N_FILTERS(NF)) dut1 (
    .clk(clk), .rst(rst), .sw(sw), .s_axis(s1_if), .m_axis(m1_if),
    .eng_start(eng1_start), .eng_sw(eng1_sw), .eng_in_data(eng1_in),
    .eng_done(eng1_done), .eng_out_data(eng1_out), .frame_err(frame1_err)
  );
  logic [2:0] dly = '0;
  logic [2:0] dly1 = '0;
  logic late_done = 1'b0;
  always @(posedge clk) begin
    dly <= {dly[1:0], eng_start};
    dly1 <= {dly1[1:0], eng1_start};
  end
  assign eng_done = dly[2] | late_done;
  assign eng1_done = dly1[2];
  assign eng1_out = eng1_in + 1'b1;
  always_comb begin
    eng_out = '0;
    for (int k = 0; k < NC; k++) eng_out[k*DW +: DW] = eng_in[k*DW +: DW] + 1'b1;
  end
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] d, input logic l);
    s_if.valid = 1'b1;
    s_if.data = d;
    s_if.last = l;
    tick();
    s_if.valid = 1'b0;
    s_if.last = 1'b0;
    s_if.data = '0;
  endtask
  task automatic wait_valid;
    int n;
    n = 0;
    while (!m_if.valid && n < 20) begin
      tick();
      n++;
    end
    chk("valid_timeout", m_if.valid, 1);
  endtask
  task automatic expect_frame(input logic [NC*DW-1:0] e);
    m_if.ready = 1'b1;
    wait_valid();
    for (int i = 0; i < NC; i++) begin
      chk("frame_data", m_if.data, e[i*DW +: DW]);
      chk("frame_last", m_if.last, i == NC - 1);
      tick();
    end
    chk("frame_idle_valid", m_if.valid, 0);
  endtask
  vec_t tv[8];
  logic [NC*DW-1:0] exp_in;
  initial begin
    tv[0] = '{24'd10, 1'b0, 24'd11};
    tv[1] = '{24'd20, 1'b0, 24'd21};
    tv[2] = '{24'd30, 1'b0, 24'd31};
    tv[3] = '{24'd40, 1'b1, 24'd41};
    tv[4] = '{24'hFFFFFB, 1'b0, 24'hFFFFFC};
    tv[5] = '{24'd0, 1'b0, 24'd1};
    tv[6] = '{24'h7FFFFF, 1'b0, 24'h800000};
    tv[7] = '{24'hFFFFFF, 1'b1, 24'd0};
    s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; m_if.ready = 1'b1;
    s1_if.valid = 1'b0; s1_if.data = '0; s1_if.last = 1'b0; m1_if.ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_s_ready", s_if.ready, 1);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_data", m_if.data, 0);
    chk("rst_m_last", m_if.last, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_sw", eng_sw, 0);
    chk("rst_eng_in", eng_in, 0);
    chk("rst_frame_err", frame_err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int f = 0; f < 2; f++) begin
      exp_in = '0;
      for (int i = 0; i < NC; i++) begin
        send(tv[4*f+i].din, tv[4*f+i].lst);
        exp_in[i*DW +: DW] = tv[4*f+i].din;
      end
      chk("start_at_T1", eng_start, 1);
      chk("ready_low_T1", s_if.ready, 0);
      chk("eng_in_frame", eng_in, exp_in);
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("no_valid_before_T5", m_if.valid, 0);
        chk("start_single_pulse", eng_start, 0);
      end
      tick();
      for (int i = 0; i < NC; i++) begin
        chk("tv_valid", m_if.valid, 1);
        chk("tv_data", m_if.data, tv[4*f+i].dout);
        chk("tv_last", m_if.last, i == NC - 1);
        tick();
      end
      chk("tv_after_valid", m_if.valid, 0);
      chk("tv_after_data", m_if.data, 0);
      chk("tv_after_ready", s_if.ready, 1);
    end
    m_if.ready = 1'b0;
    for (int i = 0; i < NC; i++) send(tv[i].din, tv[i].lst);
    wait_valid();
    for (int i = 0; i < NC; i++) begin
      chk("bp_data", m_if.data, tv[i].dout);
      chk("bp_s_ready", s_if.ready, 0);
      tick();
      chk("bp_hold_data", m_if.data, tv[i].dout);
      chk("bp_hold_last", m_if.last, i == NC - 1);
      chk("bp_hold_valid", m_if.valid, 1);
      m_if.ready = 1'b1;
      tick();
      m_if.ready = 1'b0;
    end
    chk("bp_end_s_ready", s_if.ready, 1);
    chk("bp_end_valid", m_if.valid, 0);
    chk("bp_end_data", m_if.data, 0);
    m_if.ready = 1'b1;
    sw = 4'b0010;
    send(24'd1, 1'b0); send(24'd2, 1'b0); send(24'd3, 1'b0);
    sw = 4'b0001;
    send(24'd4, 1'b1);
    sw = 4'b0100;
    chk("sw_captured", eng_sw, 4'b0001);
    wait_valid();
    chk("sw_held_emit", eng_sw, 4'b0001);
    expect_frame({24'd5, 24'd4, 24'd3, 24'd2});
    chk("sw_held_after", eng_sw, 4'b0001);
    sw = 4'b0000;
    for (int i = 0; i < NC; i++) send(tv[i].din, tv[i].lst);
    wait_valid();
    tick(); tick();
    chk("rst_mid_data", m_if.data, 24'd31);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", m_if.valid, 0);
    chk("rst_mid_s_ready", s_if.ready, 1);
    chk("rst_mid_data0", m_if.data, 0);
    chk("rst_mid_eng_in", eng_in, 0);
    tick();
    rst = 1'b0;
    tick();
    late_done = 1'b1;
    tick();
    late_done = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("late_done_no_valid", m_if.valid, 0);
      chk("late_done_ready", s_if.ready, 1);
      tick();
    end
`ifdef FIR_FRAME_CHECK_EN
    send(24'd10, 1'b0);
    send(24'd20, 1'b1);
    chk("short_frame_err", frame_err, 1);
    chk("short_no_start", eng_start, 0);
    tick();
    chk("short_err_pulse", frame_err, 0);
    chk("short_ready", s_if.ready, 1);
    send(24'd1, 1'b0); send(24'd2, 1'b0); send(24'd3, 1'b0); send(24'd4, 1'b1);
    chk("good_no_err", frame_err, 0);
    chk("good_start", eng_start, 1);
    expect_frame({24'd5, 24'd4, 24'd3, 24'd2});
    send(24'd1, 1'b0); send(24'd2, 1'b0); send(24'd3, 1'b0); send(24'd4, 1'b0);
    chk("nolast_err", frame_err, 1);
    chk("nolast_start", eng_start, 1);
    expect_frame({24'd5, 24'd4, 24'd3, 24'd2});
`else
    send(24'd1, 1'b0);
    send(24'd2, 1'b1);
    chk("stray_last_no_err", frame_err, 0);
    chk("stray_last_no_start", eng_start, 0);
    send(24'd3, 1'b0);
    send(24'd4, 1'b0);
    chk("count_frame_start", eng_start, 1);
    chk("count_frame_no_err", frame_err, 0);
    expect_frame({24'd5, 24'd4, 24'd3, 24'd2});
`endif
    for (int w = 5; w < 7; w++) begin
      int n;
      s1_if.valid = 1'b1;
      s1_if.data = DW'(w);
      tick();
      s1_if.valid = 1'b0;
      chk("n1_start", eng1_start, 1);
      n = 0;
      while (!m1_if.valid && n < 20) begin
        tick();
        n++;
      end
      chk("n1_valid", m1_if.valid, 1);
      chk("n1_data", m1_if.data, DW'(w + 1));
      chk("n1_last", m1_if.last, 1);
      tick();
      chk("n1_idle", m1_if.valid, 0);
      chk("n1_ready", s1_if.ready, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
